bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side initiator for the single-port read-first BRAM wrapper.
- Takes a burst command (start address, length) and issues one read per cycle on the RAM port.
- Tracks the RAM's fixed read latency and returns the words in order on a valid/ready output stream, with one-cycle `last` and `done` markers.
- Feeds downstream pixel/feature pipelines from frame/line buffers; backpressure is absorbed by a credit-limited output FIFO so no in-flight read is ever lost.

Parameters:
- RAM_WIDTH, 18, data width; must match the attached RAM.
- RAM_DEPTH, 1024, RAM entries; ADDR_W = clogb2(RAM_DEPTH-1).
- READ_LATENCY, 2, RAM address-to-douta cycles; 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+1, a power of 2.

Ports:
- clka  in  1  clock; everything rising-edge.
- rsta_n  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- cmd_valid  in  1  burst request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  first address.
- cmd_len  in  ADDR_W+1  word count, 0..RAM_DEPTH.
- ram_addra  out  ADDR_W  RAM address.
- ram_ena  out  1  RAM enable; high exactly on issue cycles.
- ram_wea  out  1  constant 0.
- ram_dina  out  RAM_WIDTH  constant 0.
- ram_rsta  out  1  constant 0.
- ram_regcea  out  1  constant 1.
- ram_douta  in  RAM_WIDTH  RAM read data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  RAM_WIDTH  read word.
- m_last  out  1  final word of burst, qualified by m_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, rsta_n=0):
  - state=IDLE; addr, remaining and credit counters = 0.
  - In-flight valid pipe and FIFO cleared.
  - Outputs: cmd_ready=1, ram_ena=0, ram_addra=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
  - Reset mid-burst discards all in-flight and queued data; no partial beats appear after release.
- States: IDLE, ISSUE, DRAIN.
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len>0: latch addr/len and go to ISSUE. On cmd_valid with cmd_len=0: stay IDLE and pulse done the next cycle.
  - ISSUE: issue when (fifo_count + inflight - pop_this_cycle) < FIFO_DEPTH.
    - An issue drives ram_ena=1 and ram_addra=addr, increments addr, and decrements remaining.
    - Issuing the final word moves the FSM to DRAIN.
  - DRAIN: no issues. Return to IDLE on the m_valid&m_ready beat with m_last=1; done=1 in the following cycle.
- Address wrap: addr increments modulo RAM_DEPTH (RAM_DEPTH-1 -> 0, including non-power-of-2 depths).
- Latency tracking:
  - Shift register of READ_LATENCY stages carries {valid, last} per issue.
  - Stage READ_LATENCY output writes ram_douta plus the last flag into the FIFO that same cycle.
- Credit rule guarantees the FIFO never overflows. FIFO overflow is an assertion failure.
- Stream rules:
  - Once m_valid rises, m_valid, m_data and m_last hold until m_ready.
  - m_data comes from the registered FIFO head.
  - Order equals issue order.
- Timing, handshake in cycle 0, READ_LATENCY=2, m_ready=1:
  - ram_ena=1 from cycle 1.
  - First m_valid in cycle 4.
  - Sustained rate is 1 word/cycle.
  - done in the cycle after the last beat.
- cmd_ready=0 outside IDLE; cmd_valid there is ignored (no queueing).
- remaining counter width is ADDR_W+1 so cmd_len=RAM_DEPTH works.

Decomposition:
- Package bram_rd_pkg:
  - state enum {IDLE, ISSUE, DRAIN};
  - clogb2 function;
  - FIFO entry struct {last, data} parameterised by RAM_WIDTH via macro/width constant.
- One sub-module: bram_rd_fifo.
  - Synchronous FIFO: FIFO_DEPTH entries, count output, same-cycle push/pop allowed when full or empty.
  - Async active-low clear.

Test Plan:
- Basic burst: RAM preloaded mem[i]=i^0x155; cmd_addr=0x010, cmd_len=4, m_ready=1 -> m_data 0x145,0x144,0x147,0x146 in cycles 4-7; m_last only in cycle 7; done in cycle 8; cmd_ready=1 in cycle 8.
- Wrap: cmd_addr=0x3FE, cmd_len=4 -> ram_addra 0x3FE,0x3FF,0x000,0x001; data in the same order.
- Backpressure: len=16, m_ready=0 for cycles 0-20 then 1 -> at most FIFO_DEPTH (4) ram_ena pulses before release; all 16 words in order, none duplicated.
- Zero length: cmd_len=0 -> no ram_ena, no m_valid, done pulse in cycle 1, busy never 1.
- Reset mid-burst: len=8, rsta_n=0 after the 2nd beat -> m_valid and ram_ena drop immediately. After release, a new burst (addr 0x100, len 2) returns exactly mem[0x100], mem[0x101].
- LOW_LATENCY (READ_LATENCY=1): len=RAM_DEPTH (1024) with m_ready=1 -> first m_valid in cycle 3; 1024 consecutive beats with no bubbles; m_last on beat 1024.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared state type, sizing helper and FIFO entry layout for the BRAM stream reader.
package bram_rd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} rd_state_e;
  localparam int RD_DATA_W = 18;
  typedef struct packed {
    logic                 last;
    logic [RD_DATA_W-1:0] data;
  } rd_entry_t;
  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    for (n = 0; d > 0; n++) d = d >> 1;
    return n;
  endfunction
endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: synchronous FIFO with a registered head, holding words returned by the RAM.
module bram_rd_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [PW:0]  count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign do_push = push_i && (count_q != (PW+1)'(DEPTH) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= data_i;
      wr_q    <= wr_q + PW'(do_push);
      rd_q    <= rd_q + PW'(do_pop);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> do_push);
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues one BRAM read per cycle for a burst command and returns the words
// in order on a valid/ready stream, tracking the fixed read latency with a credit-limited FIFO.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int RAM_WIDTH    = RD_DATA_W,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W      = clogb2(RAM_DEPTH - 1),
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [ADDR_W:0]      cmd_len,
  output logic [ADDR_W-1:0]    ram_addra,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic                 ram_rsta,
  output logic                 ram_regcea,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  typedef struct packed {
    logic                 last;
    logic [RAM_WIDTH-1:0] data;
  } entry_t;
  rd_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W:0]         rem_q, rem_d;
  logic [READ_LATENCY-1:0] vld_q, lst_q;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        fifo_cnt;
  entry_t                  head, tail;
  logic                    pop, issue, last_issue;
  assign ram_wea    = 1'b0;
  assign ram_dina   = '0;
  assign ram_rsta   = 1'b0;
  assign ram_regcea = 1'b1;
  assign m_valid    = fifo_cnt != '0;
  assign pop        = m_valid && m_ready;
  assign m_data     = head.data;
  assign m_last     = m_valid && head.last;
  assign cmd_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign last_issue = rem_q == (ADDR_W+1)'(1);
  // Credits cover queued words plus reads still inside the RAM pipe, so every issued read has a slot reserved.
  assign issue      = state_q == ISSUE && (int'(fifo_cnt) + $countones(vld_q) - int'(pop)) < FIFO_DEPTH;
  assign ram_ena    = issue;
  assign ram_addra  = addr_q;
  assign tail       = '{last: lst_q[READ_LATENCY-1], data: ram_douta};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = cmd_len != '0 ? ISSUE : IDLE;
        addr_d  = cmd_len != '0 ? cmd_addr : addr_q;
        rem_d   = cmd_len != '0 ? cmd_len : rem_q;
        done_d  = cmd_len == '0;
      end
      ISSUE: if (issue) begin
        addr_d  = addr_q == ADDR_W'(RAM_DEPTH - 1) ? '0 : addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = last_issue ? DRAIN : ISSUE;
      end
      DRAIN: if (pop && head.last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      vld_q   <= (vld_q << 1) | READ_LATENCY'(issue);
      lst_q   <= (lst_q << 1) | READ_LATENCY'(issue && last_issue);
      done_q  <= done_d;
    end
  end
  bram_rd_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clka),
    .rst_ni (rsta_n),
    .push_i (vld_q[READ_LATENCY-1]),
    .data_i (tail),
    .pop_i  (pop),
    .data_o (head),
    .count_o(fifo_cnt)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized and directed checks of the reader against a behavioural RAM and stream model.
module tb_bram_stream_reader;
  localparam int MAXC = 1100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [17:0] mem [1024];
  logic        a_cmd_valid = 1'b0, a_cmd_ready, a_ram_ena, a_ram_wea, a_ram_rsta, a_ram_regcea;
  logic [9:0]  a_cmd_addr = '0, a_ram_addra;
  logic [10:0] a_cmd_len = '0;
  logic [17:0] a_ram_dina, a_m_data, a_p1, a_p2;
  logic        a_m_valid, a_m_ready = 1'b1, a_m_last, a_busy, a_done;
  logic        b_cmd_valid = 1'b0, b_cmd_ready, b_ram_ena, b_ram_wea, b_ram_rsta, b_ram_regcea;
  logic [9:0]  b_cmd_addr = '0, b_ram_addra;
  logic [10:0] b_cmd_len = '0;
  logic [17:0] b_ram_dina, b_m_data, b_p1;
  logic        b_m_valid, b_m_ready = 1'b1, b_m_last, b_busy, b_done;
  int checks = 0;
  int errors = 0;
  logic        cap_v [MAXC], cap_r [MAXC], cap_l [MAXC], cap_dn [MAXC], cap_cr [MAXC], cap_e [MAXC], cap_b [MAXC];
  logic [17:0] cap_d [MAXC];
  logic [9:0]  cap_a [MAXC];

  bram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
    .clka(clk), .rsta_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr),
    .cmd_len(a_cmd_len), .ram_addra(a_ram_addra), .ram_ena(a_ram_ena), .ram_wea(a_ram_wea), .ram_dina(a_ram_dina),
    .ram_rsta(a_ram_rsta), .ram_regcea(a_ram_regcea), .ram_douta(a_p2), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_data(a_m_data), .m_last(a_m_last), .busy(a_busy), .done(a_done));
  bram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut_b (
    .clka(clk), .rsta_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr),
    .cmd_len(b_cmd_len), .ram_addra(b_ram_addra), .ram_ena(b_ram_ena), .ram_wea(b_ram_wea), .ram_dina(b_ram_dina),
    .ram_rsta(b_ram_rsta), .ram_regcea(b_ram_regcea), .ram_douta(b_p1), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_data(b_m_data), .m_last(b_m_last), .busy(b_busy), .done(b_done));

  // Behavioural RAMs: two-stage (HIGH_PERFORMANCE) for a, single-stage (LOW_LATENCY) for b.
  always @(posedge clk) begin
    if (a_ram_ena) a_p1 <= mem[a_ram_addra];
    a_p2 <= a_p1;
    if (b_ram_ena) b_p1 <= mem[b_ram_addra];
  end

  task automatic run(input bit sel, input logic [9:0] addr, input logic [10:0] len, input int ncyc, input int mode, input int hold);
    for (int c = 0; c < ncyc; c++) begin
      logic r;
      r = mode == 0 ? 1'b1 : mode == 1 ? (c > hold) : ($urandom_range(0, 9) < 7);
      if (sel) begin
        b_cmd_valid = (c == 0); b_cmd_addr = addr; b_cmd_len = len; b_m_ready = r;
      end else begin
        a_cmd_valid = (c == 0); a_cmd_addr = addr; a_cmd_len = len; a_m_ready = r;
      end
      @(negedge clk);
      cap_r[c]  = r;
      cap_v[c]  = sel ? b_m_valid : a_m_valid;
      cap_d[c]  = sel ? b_m_data : a_m_data;
      cap_l[c]  = sel ? b_m_last : a_m_last;
      cap_dn[c] = sel ? b_done : a_done;
      cap_cr[c] = sel ? b_cmd_ready : a_cmd_ready;
      cap_e[c]  = sel ? b_ram_ena : a_ram_ena;
      cap_a[c]  = sel ? b_ram_addra : a_ram_addra;
      cap_b[c]  = sel ? b_busy : a_busy;
      @(posedge clk); #1;
    end
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
    a_m_ready = 1'b1;
    b_m_ready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_cmd_ready, a_ram_ena, a_m_valid, a_m_last, a_busy, a_done} !== 6'b100000) begin
      errors++; $display("FAIL reset_status got %b exp 100000", {a_cmd_ready, a_ram_ena, a_m_valid, a_m_last, a_busy, a_done});
    end
    checks++;
    if (a_ram_addra !== 10'h0 || a_m_data !== 18'h0) begin
      errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", a_ram_addra, a_m_data);
    end
    checks++;
    if ({a_ram_wea, a_ram_rsta, a_ram_regcea, a_ram_dina} !== {3'b001, 18'h0}) begin
      errors++; $display("FAIL reset_ram_consts got %b%b%b/%h exp 001/0", a_ram_wea, a_ram_rsta, a_ram_regcea, a_ram_dina);
    end
    checks++;
    if ({b_cmd_ready, b_ram_ena, b_m_valid, b_busy, b_done} !== 5'b10000) begin
      errors++; $display("FAIL reset_status_ll got %b exp 10000", {b_cmd_ready, b_ram_ena, b_m_valid, b_busy, b_done});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [17:0] exp_d [4] = '{18'h145, 18'h144, 18'h147, 18'h146};
    run(1'b0, 10'h010, 11'd4, 10, 0, 0);
    for (int c = 0; c < 10; c++) begin
      logic ev, el, ed, er, ee;
      ev = c >= 4 && c <= 7; el = c == 7; ed = c == 8; er = c == 0 || c >= 8; ee = c >= 1 && c <= 4;
      checks++; if (cap_v[c] !== ev) begin errors++; $display("FAIL basic_valid c=%0d got %b exp %b", c, cap_v[c], ev); end
      checks++; if (cap_l[c] !== el) begin errors++; $display("FAIL basic_last c=%0d got %b exp %b", c, cap_l[c], el); end
      checks++; if (cap_dn[c] !== ed) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, cap_dn[c], ed); end
      checks++; if (cap_cr[c] !== er) begin errors++; $display("FAIL basic_cmd_ready c=%0d got %b exp %b", c, cap_cr[c], er); end
      checks++; if (cap_e[c] !== ee) begin errors++; $display("FAIL basic_ena c=%0d got %b exp %b", c, cap_e[c], ee); end
      if (ev) begin
        checks++; if (cap_d[c] !== exp_d[c-4]) begin errors++; $display("FAIL basic_data c=%0d got %h exp %h", c, cap_d[c], exp_d[c-4]); end
      end
      if (ee) begin
        checks++; if (cap_a[c] !== 10'(15 + c)) begin errors++; $display("FAIL basic_addr c=%0d got %h exp %h", c, cap_a[c], 10'(15 + c)); end
      end
    end
  endtask

  task automatic test_wrap();
    int n, nb;
    run(1'b0, 10'h3FE, 11'd4, 12, 0, 0);
    n = 0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      if (cap_e[c]) begin
        checks++;
        if (n >= 4 || cap_a[c] !== 10'((1022 + n) % 1024)) begin errors++; $display("FAIL wrap_addr n=%0d got %h exp %h", n, cap_a[c], 10'((1022 + n) % 1024)); end
        n++;
      end
      if (cap_v[c] && cap_r[c]) begin
        checks++;
        if (nb >= 4 || cap_d[c] !== mem[(1022 + nb) % 1024] || cap_l[c] !== (nb == 3)) begin
          errors++; $display("FAIL wrap_beat n=%0d got %h/%b exp %h/%b", nb, cap_d[c], cap_l[c], mem[(1022 + nb) % 1024], nb == 3);
        end
        nb++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL wrap_issues got %0d exp 4", n); end
    checks++; if (nb != 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", nb); end
  endtask

  task automatic test_backpressure();
    int ne, nb, nd;
    run(1'b0, 10'h040, 11'd16, 50, 1, 20);
    ne = 0; nb = 0; nd = 0;
    for (int c = 0; c < 50; c++) begin
      if (c <= 20 && cap_e[c]) ne++;
      if (cap_dn[c]) nd++;
      if (cap_v[c] && cap_r[c]) begin
        checks++;
        if (nb >= 16 || cap_d[c] !== mem[64 + nb] || cap_l[c] !== (nb == 15)) begin
          errors++; $display("FAIL bp_beat n=%0d got %h/%b exp %h/%b", nb, cap_d[c], cap_l[c], mem[64 + nb], nb == 15);
        end
        nb++;
      end
    end
    checks++; if (ne < 1 || ne > 4) begin errors++; $display("FAIL bp_issues_before_ready got %0d exp 1..4", ne); end
    checks++; if (nb != 16) begin errors++; $display("FAIL bp_beats got %0d exp 16", nb); end
    checks++; if (nd != 1) begin errors++; $display("FAIL bp_done_pulses got %0d exp 1", nd); end
  endtask

  task automatic test_zero_len();
    run(1'b0, 10'h055, 11'd0, 6, 0, 0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({cap_e[c], cap_v[c], cap_b[c], cap_cr[c], cap_dn[c]} !== {4'b0001, c == 1}) begin
        errors++; $display("FAIL zero_len c=%0d got %b exp %b", c, {cap_e[c], cap_v[c], cap_b[c], cap_cr[c], cap_dn[c]}, {4'b0001, c == 1});
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb, c;
    nb = 0; c = 0;
    a_cmd_valid = 1'b1; a_cmd_addr = 10'h020; a_cmd_len = 11'd8; a_m_ready = 1'b1;
    while (nb < 2 && c < 20) begin
      @(negedge clk);
      if (a_m_valid && a_m_ready) nb++;
      @(posedge clk); #1;
      a_cmd_valid = 1'b0;
      c++;
    end
    checks++; if (nb != 2) begin errors++; $display("FAIL rmid_two_beats got %0d exp 2", nb); end
    checks++; if (a_ram_ena !== 1'b1) begin errors++; $display("FAIL rmid_issuing got %b exp 1", a_ram_ena); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_m_valid, a_ram_ena, a_busy, a_cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL rmid_drop got %b exp 0001", {a_m_valid, a_ram_ena, a_busy, a_cmd_ready});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run(1'b0, 10'h100, 11'd2, 12, 0, 0);
    nb = 0;
    for (int k = 0; k < 12; k++) if (cap_v[k] && cap_r[k]) begin
      checks++;
      if (nb >= 2 || cap_d[k] !== mem[256 + nb] || cap_l[k] !== (nb == 1)) begin
        errors++; $display("FAIL rmid_beat n=%0d got %h/%b exp %h/%b", nb, cap_d[k], cap_l[k], mem[256 + nb], nb == 1);
      end
      nb++;
    end
    checks++; if (nb != 2) begin errors++; $display("FAIL rmid_beats got %0d exp 2", nb); end
  endtask

  task automatic test_low_latency();
    int first, bubbles, nb;
    run(1'b1, 10'h2A5, 11'd1024, 1032, 0, 0);
    first = -1; bubbles = 0; nb = 0;
    for (int c = 0; c < 1032; c++) begin
      if (first < 0 && cap_v[c]) first = c;
      if (c >= 3 && c <= 1026 && !cap_v[c]) bubbles++;
      if (cap_v[c] && cap_r[c]) begin
        if (nb >= 1024 || cap_d[c] !== mem[(677 + nb) % 1024] || cap_l[c] !== (nb == 1023)) begin
          checks++; errors++;
          $display("FAIL ll_beat n=%0d got %h/%b exp %h/%b", nb, cap_d[c], cap_l[c], mem[(677 + nb) % 1024], nb == 1023);
        end else checks++;
        nb++;
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL ll_first_valid got %0d exp 3", first); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL ll_bubbles got %0d exp 0", bubbles); end
    checks++; if (nb != 1024) begin errors++; $display("FAIL ll_beats got %0d exp 1024", nb); end
    checks++; if (cap_dn[1027] !== 1'b1) begin errors++; $display("FAIL ll_done got %b exp 1", cap_dn[1027]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
    for (int t = 0; t < 6; t++) begin
      int addr, len, ncyc, nb, lc, nd;
      addr = $urandom_range(0, 1023);
      len = $urandom_range(1, 40);
      ncyc = len * 4 + 24;
      run(1'b0, 10'(addr), 11'(len), ncyc, 2, 0);
      nb = 0; lc = -1; nd = 0;
      for (int c = 0; c < ncyc; c++) begin
        if (cap_dn[c]) nd++;
        if (c < ncyc - 1 && cap_v[c] && !cap_r[c]) begin
          checks++;
          if (cap_v[c+1] !== 1'b1 || cap_d[c+1] !== cap_d[c] || cap_l[c+1] !== cap_l[c]) begin
            errors++; $display("FAIL rnd_hold t=%0d c=%0d got %b/%h exp 1/%h", t, c, cap_v[c+1], cap_d[c+1], cap_d[c]);
          end
        end
        if (cap_v[c] && cap_r[c]) begin
          checks++;
          if (nb >= len || cap_d[c] !== mem[(addr + nb) % 1024] || cap_l[c] !== (nb == len - 1)) begin
            errors++; $display("FAIL rnd_beat t=%0d n=%0d got %h/%b exp %h/%b", t, nb, cap_d[c], cap_l[c], mem[(addr + nb) % 1024], nb == len - 1);
          end
          if (cap_l[c]) lc = c;
          nb++;
        end
      end
      checks++; if (nb != len) begin errors++; $display("FAIL rnd_beats t=%0d got %0d exp %0d", t, nb, len); end
      checks++;
      if (lc < 0 || lc + 1 >= ncyc || cap_dn[lc+1] !== 1'b1 || nd != 1) begin
        errors++; $display("FAIL rnd_done t=%0d last_cycle=%0d pulses=%0d exp done after last, 1 pulse", t, lc, nd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 18'(i ^ 'h155);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_low_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
